pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Parametrised hazard and flow controller for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB pipeline registers).
- Tracks a valid bit and a halt tag per pipeline register.
- Detects RAW and load-use hazards against the ID-stage source registers, generates operand-forward selects, stalls and squashes.
- Sequences halt drain.
- The processor top ANDs every write-enable and store with the matching `valid_po` bit.

## Interface
Parameters:
- `REG_AW`, 5: register-address width. Register 0 is treated like any other register.
- `CNT_W`, 16: stall-counter width.

Ports:
- `CLK_pi` in 1: the block's only clock.
- `CPU_RESET_N_pi` in 1: synchronous, active-low reset.
- `id_rs_pi`, `id_rt_pi` in `REG_AW`: source registers of the instruction in IF/ID.
- `id_uses_rs_pi`, `id_uses_rt_pi` in 1: the ID instruction actually reads rs / rt.
- `id_is_halt_pi` in 1: the ID instruction is HALT.
- `ex_rd_pi`, `ex_we_pi`, `ex_is_load_pi` in `REG_AW`/1/1: destination fields of ID/EX.
- `mem_rd_pi`, `mem_we_pi` in `REG_AW`/1: destination fields of EX/MEM.
- `wb_rd_pi`, `wb_we_pi` in `REG_AW`/1: destination fields of MEM/WB.
- `branch_taken_pi` in 1: taken-branch output of the branch unit, evaluated on EX/MEM.
- `stall_if_po` out 1: hold the PC and IF/ID.
- `bubble_ex_po` out 1: load a bubble into ID/EX.
- `flush_po` out 1: a taken branch squashes IF/ID, ID/EX and EX/MEM.
- `fwd_a_sel_po`, `fwd_b_sel_po` out 2: operand source for rs / rt.
  - 0: register file
  - 1: EX ALU result
  - 2: MEM result (load data or ALU result)
  - 3: WB write data
- `valid_po` out 4: valid bits; bit0 = IF/ID … bit3 = MEM/WB.
- `halted_po` out 1: the core has halted.
- `stall_count_po` out `CNT_W`: saturating count of stall cycles.

## Operation
- Hazard qualification:
  - EX producer counts only when `valid[1]`; MEM only when `valid[2]`; WB only when `valid[3]`.
  - The producer's we must be 1 and its rd must equal the consumed source, with the matching `id_uses_*` set.
  - The consumer counts only when `valid[0]`.
- Forwarding, with `PIPE_HAZ_FWD_EN`:
  - Each operand takes the youngest matching producer, priority EX > MEM > WB, else 0.
  - Load-use: an EX producer with `ex_is_load_pi`=1 matching either source raises stall for exactly one cycle. Next cycle the load is in MEM and the select is 2.
- Stall:
  - `stall_if_po`=1 and `bubble_ex_po`=1.
  - Next cycle: `valid[0]` holds, `valid[1]`=0, `valid[3:2]` shift normally.
- Flush:
  - Condition: `branch_taken_pi` & `valid[2]`.
  - `flush_po`=1. Next cycle `valid[2:0]`=0 and `valid[3]` takes the branch.
  - Flush overrides stall; `stall_if_po`=0 and the PC takes the target.
- Normal advance: `valid[0]`<=1 in RUN, then `valid[i]`<=`valid[i-1]`.
- States:
  - RUN: normal operation.
  - DRAIN: entered when a valid, unstalled, unflushed HALT leaves ID. The halt tag enters ID/EX, `stall_if_po`=1, and `valid[0]`<=0.
  - HALTED: entered when the halt tag reaches MEM/WB. `halted_po`=1 and `stall_if_po`=1. HALTED is left only by reset.
- Flush in DRAIN: a flush while the halt tag is in ID/EX or EX/MEM clears the tag and returns to RUN, because the halt was on the wrong path.
- Halt tags shift with the valid bits and are cleared by flush and bubble.
- Stall counter: +1 per stall cycle, saturates at all-ones, never wraps.

## Timing
- Reset values: `valid_po`=0, all halt tags 0, state RUN, `halted_po`=0, `stall_count_po`=0.
  - Combinational outputs are 0 while `valid_po`=0: `stall_if_po`, `bubble_ex_po`, `flush_po`, `fwd_*`.
- Reset has priority over everything. Asserted mid-drain or mid-stall, the block is in RUN with all-zero state on the next edge.
- `stall_if_po`, `bubble_ex_po`, `flush_po` and `fwd_*` are combinational from the inputs and current state, with no registered latency.
- `valid_po`, `halted_po` and `stall_count_po` are registered.
- The first fetched instruction is valid in IF/ID one edge after reset deassertion.
- HALT in ID at cycle t, no flush: DRAIN from t+1, `halted_po`=1 from t+3.

## Configuration
- `PIPE_HAZ_FWD_EN` defined: forwarding and one-cycle load-use stall as above.
- `PIPE_HAZ_FWD_EN` undefined: interlock only.
  - `fwd_*_sel_po` are tied to 0.
  - Stall while any qualified EX, MEM or WB producer matches a used source.
  - The WB match is included because there is no register-file write-through.

## Test plan
- Reset:
  - Hold reset low for 3 cycles with random inputs → all outputs 0 throughout.
  - One edge after deassert → `valid_po`=4'b0001.
- Forward priority (FWD_EN):
  - `ex_rd`=`mem_rd`=3, both we=1, `id_rs`=3 → `fwd_a_sel_po`=1.
  - Drop `ex_we` → `fwd_a_sel_po`=2.
- Load-use:
  - EX is a load to r5, `id_rt`=5 used → `stall_if_po`=`bubble_ex_po`=1 for exactly 1 cycle, then `fwd_b_sel_po`=2.
  - `stall_count_po` increments 0→1.
- Branch flush:
  - `branch_taken_pi`=1, `valid_po`=4'b1111, stall condition also present → `flush_po`=1, `stall_if_po`=0.
  - Next `valid_po`=4'b1000.
- Halt:
  - HALT valid in ID, no hazards → DRAIN.
  - `halted_po`=1 exactly 3 edges later and stays 1.
  - Repeat with `branch_taken_pi` while the tag is in ID/EX → return to RUN, `halted_po` stays 0.
- Interlock (FWD_EN undefined):
  - WB producer r7, `id_rs`=7 → stall 1 cycle with `fwd_a_sel_po`=0.
  - Counter at all-ones stays at all-ones.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline hazard/flow controller; forwarding enabled by PIPE_HAZ_FWD_EN
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK_pi,
  input  logic              CPU_RESET_N_pi,
  input  logic [REG_AW-1:0] id_rs_pi,
  input  logic [REG_AW-1:0] id_rt_pi,
  input  logic              id_uses_rs_pi,
  input  logic              id_uses_rt_pi,
  input  logic              id_is_halt_pi,
  input  logic [REG_AW-1:0] ex_rd_pi,
  input  logic              ex_we_pi,
  input  logic              ex_is_load_pi,
  input  logic [REG_AW-1:0] mem_rd_pi,
  input  logic              mem_we_pi,
  input  logic [REG_AW-1:0] wb_rd_pi,
  input  logic              wb_we_pi,
  input  logic              branch_taken_pi,
  output logic              stall_if_po,
  output logic              bubble_ex_po,
  output logic              flush_po,
  output logic [1:0]        fwd_a_sel_po,
  output logic [1:0]        fwd_b_sel_po,
  output logic [3:0]        valid_po,
  output logic              halted_po,
  output logic [CNT_W-1:0]  stall_count_po
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  state_t           state;
  logic [3:0]       valid;
  // Halt tags for ID/EX and EX/MEM; the tag reaching MEM/WB is the HALTED state itself.
  logic [2:1]       halt_tag;
  logic [CNT_W-1:0] stall_cnt;

  logic ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit, wb_rs_hit, wb_rt_hit;
  logic hazard_stall, flush, halt_leave;

  // Producer/consumer matches, each qualified by the valid bits of both stages.
  assign ex_rs_hit  = valid[0] & id_uses_rs_pi & valid[1] & ex_we_pi  & (ex_rd_pi  == id_rs_pi);
  assign ex_rt_hit  = valid[0] & id_uses_rt_pi & valid[1] & ex_we_pi  & (ex_rd_pi  == id_rt_pi);
  assign mem_rs_hit = valid[0] & id_uses_rs_pi & valid[2] & mem_we_pi & (mem_rd_pi == id_rs_pi);
  assign mem_rt_hit = valid[0] & id_uses_rt_pi & valid[2] & mem_we_pi & (mem_rd_pi == id_rt_pi);
  assign wb_rs_hit  = valid[0] & id_uses_rs_pi & valid[3] & wb_we_pi  & (wb_rd_pi  == id_rs_pi);
  assign wb_rt_hit  = valid[0] & id_uses_rt_pi & valid[3] & wb_we_pi  & (wb_rd_pi  == id_rt_pi);

`ifdef PIPE_HAZ_FWD_EN
  // Only a load in EX cannot be forwarded yet; everything else is bypassed.
  assign hazard_stall = (ex_rs_hit | ex_rt_hit) & ex_is_load_pi;

  // Youngest producer wins: EX, then MEM, then WB, else register file.
  always_comb begin
    fwd_a_sel_po = 2'd0;
    fwd_b_sel_po = 2'd0;
    if (ex_rs_hit)       fwd_a_sel_po = 2'd1;
    else if (mem_rs_hit) fwd_a_sel_po = 2'd2;
    else if (wb_rs_hit)  fwd_a_sel_po = 2'd3;
    if (ex_rt_hit)       fwd_b_sel_po = 2'd1;
    else if (mem_rt_hit) fwd_b_sel_po = 2'd2;
    else if (wb_rt_hit)  fwd_b_sel_po = 2'd3;
  end
`else
  logic unused_ex_is_load;
  assign unused_ex_is_load = ex_is_load_pi;

  // Pure interlock: WB counts too since the register file has no write-through.
  assign hazard_stall = ex_rs_hit | ex_rt_hit | mem_rs_hit | mem_rt_hit | wb_rs_hit | wb_rt_hit;
  assign fwd_a_sel_po = 2'd0;
  assign fwd_b_sel_po = 2'd0;
`endif

  assign flush        = branch_taken_pi & valid[2];
  assign flush_po     = flush;
  assign bubble_ex_po = hazard_stall & ~flush;
  assign stall_if_po  = ~flush & (hazard_stall | (state != ST_RUN));
  assign halt_leave   = (state == ST_RUN) & valid[0] & id_is_halt_pi & ~hazard_stall & ~flush;

  assign valid_po       = valid;
  assign halted_po      = (state == ST_HALTED);
  assign stall_count_po = stall_cnt;

  // Valid/halt-tag shifting, halt-drain FSM and saturating stall counter.
  always_ff @(posedge CLK_pi) begin
    if (!CPU_RESET_N_pi) begin
      valid     <= '0;
      halt_tag  <= '0;
      state     <= ST_RUN;
      stall_cnt <= '0;
    end else begin
      if (bubble_ex_po && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

      if (flush) begin
        valid    <= {valid[2], 3'b000};
        halt_tag <= '0;
        if (state == ST_DRAIN) state <= ST_RUN;
      end else begin
        if (hazard_stall) begin
          valid    <= {valid[2], valid[1], 1'b0, valid[0]};
          halt_tag <= {halt_tag[1], 1'b0};
        end else begin
          valid    <= {valid[2:0], (state == ST_RUN) & ~halt_leave};
          halt_tag <= {halt_tag[1], halt_leave};
        end
        if ((state == ST_DRAIN) && halt_tag[2]) state <= ST_HALTED;
        else if (halt_leave)                     state <= ST_DRAIN;
      end
    end
  end

endmodule
